// File: rtl/mem_check_pkg.sv
// Shared state encoding, failure codes and width helper for the store-checking monitor.
package mem_check_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        RUN,
        DONE
    } state_e;

    localparam logic [1:0] FAIL_NONE     = 2'd0;
    localparam logic [1:0] FAIL_TIMEOUT  = 2'd1;
    localparam logic [1:0] FAIL_MISMATCH = 2'd2;
    localparam logic [1:0] FAIL_BADSEL   = 2'd3;

    // Index width that stays legal (>= 1 bit) for degenerate sizes.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_check_monitor_exp_table.sv
// Expected-store table: NUM_TESTS x MAX_CHECKS {addr, data} entries plus per-slot counts.
module exp_table
    import mem_check_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned NUM_TESTS  = 6,
    parameter int unsigned MAX_CHECKS = 4
) (
    input  logic                                 clk_i,
    input  logic                                 reset_ni,
    input  logic                                 wr_en_i,
    input  logic                                 cnt_we_i,
    input  logic [idx_w(NUM_TESTS)-1:0]          wr_test_i,
    input  logic [idx_w(MAX_CHECKS)-1:0]         wr_idx_i,
    input  logic [WIDTH-1:0]                     wr_addr_i,
    input  logic [WIDTH-1:0]                     wr_data_i,
    input  logic [idx_w(MAX_CHECKS+1)-1:0]       cnt_i,
    input  logic [idx_w(NUM_TESTS)-1:0]          rd_test_i,
    input  logic [idx_w(MAX_CHECKS+1)-1:0]       rd_idx_i,
    output logic [WIDTH-1:0]                     rd_addr_o,
    output logic [WIDTH-1:0]                     rd_data_o,
    output logic [idx_w(MAX_CHECKS+1)-1:0]       rd_cnt_o
);

    localparam int unsigned IW = idx_w(MAX_CHECKS);
    localparam int unsigned KW = idx_w(MAX_CHECKS + 1);

    logic [WIDTH-1:0] addr_q [NUM_TESTS][MAX_CHECKS];
    logic [WIDTH-1:0] data_q [NUM_TESTS][MAX_CHECKS];
    logic [KW-1:0]    cnt_q  [NUM_TESTS];

    logic          wr_ok;
    logic          cnt_ok;
    logic          rd_slot_ok;
    logic          rd_ok;
    logic [KW-1:0] cnt_clamped;

    assign wr_ok      = wr_en_i && (32'(wr_test_i) < NUM_TESTS) && (32'(wr_idx_i) < MAX_CHECKS);
    assign cnt_ok     = cnt_we_i && (32'(wr_test_i) < NUM_TESTS);
    assign rd_slot_ok = (32'(rd_test_i) < NUM_TESTS);
    assign rd_ok      = rd_slot_ok && (32'(rd_idx_i) < MAX_CHECKS);

    // A count above the slot depth would walk the match index off the table.
    assign cnt_clamped = (32'(cnt_i) > MAX_CHECKS) ? KW'(MAX_CHECKS) : cnt_i;

    always_ff @(posedge clk_i) begin
        if (wr_ok) begin
            addr_q[wr_test_i][wr_idx_i] <= wr_addr_i;
            data_q[wr_test_i][wr_idx_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            for (int t = 0; t < NUM_TESTS; t++) begin
                cnt_q[t] <= '0;
            end
        end else if (cnt_ok) begin
            cnt_q[wr_test_i] <= cnt_clamped;
        end
    end

    always_comb begin
        rd_addr_o = '0;
        rd_data_o = '0;
        rd_cnt_o  = '0;
        if (rd_slot_ok) begin
            rd_cnt_o = cnt_q[rd_test_i];
        end
        if (rd_ok) begin
            rd_addr_o = addr_q[rd_test_i][rd_idx_i[IW-1:0]];
            rd_data_o = data_q[rd_test_i][rd_idx_i[IW-1:0]];
        end
    end

endmodule

// File: rtl/mem_check_monitor.sv
// Test sequencer: holds the CPU in reset, then checks its store bus against the expected table.
// state | meaning
// IDLE  | waiting for start; CPU held in reset
// HOLD  | dut_reset asserted for RESET_CYCLES cycles
// RUN   | CPU running; stores matched in order, cycles counted
// DONE  | one-cycle result strobe
module mem_check_monitor
    import mem_check_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned NUM_TESTS    = 6,
    parameter int unsigned MAX_CHECKS   = 4,
    parameter int unsigned TIMEOUT      = 200,
    parameter int unsigned RESET_CYCLES = 2,
    parameter bit          STRICT       = 1'b0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               exp_we,
    input  logic [idx_w(NUM_TESTS)-1:0]        exp_test,
    input  logic [idx_w(MAX_CHECKS)-1:0]       exp_idx,
    input  logic [WIDTH-1:0]                   exp_addr,
    input  logic [WIDTH-1:0]                   exp_data,
    input  logic                               exp_cnt_we,
    input  logic [idx_w(MAX_CHECKS+1)-1:0]     exp_cnt,
    input  logic                               start,
    input  logic [idx_w(NUM_TESTS)-1:0]        test_sel,
    input  logic                               memwrite,
    input  logic [WIDTH-1:0]                   dataadr,
    input  logic [WIDTH-1:0]                   writedata,
    output logic                               dut_reset,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [1:0]                         fail_code,
    output logic [idx_w(TIMEOUT+1)-1:0]        cycles,
    output logic [7:0]                         stray,
    output logic [idx_w(NUM_TESTS+1)-1:0]      pass_total,
    output logic [WIDTH-1:0]                   bad_addr,
    output logic [WIDTH-1:0]                   bad_data
);

    localparam int unsigned TW  = idx_w(NUM_TESTS);
    localparam int unsigned KW  = idx_w(MAX_CHECKS + 1);
    localparam int unsigned CYW = idx_w(TIMEOUT + 1);
    localparam int unsigned PW  = idx_w(NUM_TESTS + 1);
    localparam int unsigned HW  = idx_w(RESET_CYCLES);

    state_e           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CYW-1:0]   cyc_q, cyc_d;
    logic [KW-1:0]    k_q, k_d;
    logic [TW-1:0]    sel_q, sel_d;
    logic [7:0]       stray_q, stray_d;
    logic             bad_seen_q, bad_seen_d;
    logic [WIDTH-1:0] bad_addr_q, bad_addr_d;
    logic [WIDTH-1:0] bad_data_q, bad_data_d;
    logic             pass_q, pass_d;
    logic [1:0]       fail_q, fail_d;
    logic [PW-1:0]    total_q, total_d;

    logic [WIDTH-1:0] tbl_addr;
    logic [WIDTH-1:0] tbl_data;
    logic [KW-1:0]    tbl_cnt;

    logic             hit;
    logic             miss;
    logic             last_hit;
    logic             timeout;
    logic             won;
    logic [CYW-1:0]   cyc_inc;
    logic [7:0]       stray_inc;

    exp_table #(
        .WIDTH      (WIDTH),
        .NUM_TESTS  (NUM_TESTS),
        .MAX_CHECKS (MAX_CHECKS)
    ) u_exp_table (
        .clk_i     (clk),
        .reset_ni  (reset),
        .wr_en_i   (exp_we),
        .cnt_we_i  (exp_cnt_we),
        .wr_test_i (exp_test),
        .wr_idx_i  (exp_idx),
        .wr_addr_i (exp_addr),
        .wr_data_i (exp_data),
        .cnt_i     (exp_cnt),
        .rd_test_i (sel_q),
        .rd_idx_i  (k_q),
        .rd_addr_o (tbl_addr),
        .rd_data_o (tbl_data),
        .rd_cnt_o  (tbl_cnt)
    );

    // A zero-count slot can never produce a hit, so it only resolves at timeout.
    assign hit       = memwrite && (k_q < tbl_cnt) && (dataadr == tbl_addr) && (writedata == tbl_data);
    assign miss      = memwrite && !hit;
    assign last_hit  = hit && ((k_q + KW'(1)) == tbl_cnt);
    assign cyc_inc   = cyc_q + CYW'(1);
    assign timeout   = (cyc_inc == CYW'(TIMEOUT));
    assign stray_inc = (miss && (stray_q != 8'hFF)) ? stray_q + 8'd1 : stray_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            hold_q     <= '0;
            cyc_q      <= '0;
            k_q        <= '0;
            sel_q      <= '0;
            stray_q    <= '0;
            bad_seen_q <= 1'b0;
            bad_addr_q <= '0;
            bad_data_q <= '0;
            pass_q     <= 1'b0;
            fail_q     <= FAIL_NONE;
            total_q    <= '0;
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cyc_q      <= cyc_d;
            k_q        <= k_d;
            sel_q      <= sel_d;
            stray_q    <= stray_d;
            bad_seen_q <= bad_seen_d;
            bad_addr_q <= bad_addr_d;
            bad_data_q <= bad_data_d;
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            total_q    <= total_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cyc_d      = cyc_q;
        k_d        = k_q;
        sel_d      = sel_q;
        stray_d    = stray_q;
        bad_seen_d = bad_seen_q;
        bad_addr_d = bad_addr_q;
        bad_data_d = bad_data_q;
        pass_d     = pass_q;
        fail_d     = fail_q;
        total_d    = total_q;
        won        = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    pass_d     = 1'b0;
                    fail_d     = FAIL_NONE;
                    cyc_d      = '0;
                    k_d        = '0;
                    stray_d    = '0;
                    bad_seen_d = 1'b0;
                    bad_addr_d = '0;
                    bad_data_d = '0;
                    if (32'(test_sel) < NUM_TESTS) begin
                        sel_d   = test_sel;
                        hold_d  = HW'(RESET_CYCLES - 1);
                        state_d = HOLD;
                    end else begin
                        fail_d  = FAIL_BADSEL;
                        state_d = DONE;
                    end
                end
            end

            HOLD: begin
                if (hold_q == '0) begin
                    state_d = RUN;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end

            RUN: begin
                cyc_d   = cyc_inc;
                stray_d = stray_inc;
                if (hit) begin
                    k_d = k_q + KW'(1);
                end
                if (miss && !bad_seen_q) begin
                    bad_seen_d = 1'b1;
                    bad_addr_d = dataadr;
                    bad_data_d = writedata;
                end
                // Priority: completing match, then strict mismatch, then timeout.
                if (last_hit) begin
                    won     = 1'b1;
                    state_d = DONE;
                end else if (STRICT && miss) begin
                    fail_d  = FAIL_MISMATCH;
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = DONE;
                    if ((tbl_cnt == '0) && (stray_inc == 8'd0)) begin
                        won = 1'b1;
                    end else begin
                        fail_d = FAIL_TIMEOUT;
                    end
                end
                if (won) begin
                    pass_d = 1'b1;
                    if (total_q != PW'(NUM_TESTS)) begin
                        total_d = total_q + PW'(1);
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dut_reset  = (state_q != RUN);
    assign busy       = (state_q == HOLD) || (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign fail_code  = fail_q;
    assign cycles     = cyc_q;
    assign stray      = stray_q;
    assign pass_total = total_q;
    assign bad_addr   = bad_addr_q;
    assign bad_data   = bad_data_q;

endmodule

// File: tb/tb_mem_check_monitor.sv
// Directed bench for mem_check_monitor; a lenient and a strict instance share all stimulus.
module tb_mem_check_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        exp_we = 1'b0;
    logic        exp_cnt_we = 1'b0;
    logic        start = 1'b0;
    logic        memwrite = 1'b0;
    logic [2:0]  exp_test = '0;
    logic [1:0]  exp_idx = '0;
    logic [31:0] exp_addr = '0;
    logic [31:0] exp_data = '0;
    logic [2:0]  exp_cnt = '0;
    logic [2:0]  test_sel = '0;
    logic [31:0] dataadr = '0;
    logic [31:0] writedata = '0;

    logic        dut_reset, busy, done, pass;
    logic [1:0]  fail_code;
    logic [7:0]  cycles, stray;
    logic [2:0]  pass_total;
    logic [31:0] bad_addr, bad_data;

    logic        dut_reset_s, busy_s, done_s, pass_s;
    logic [1:0]  fail_code_s;
    logic [7:0]  cycles_s, stray_s;
    logic [2:0]  pass_total_s;
    logic [31:0] bad_addr_s, bad_data_s;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] t_addr [6][2];
    logic [31:0] t_data [6][2];
    int          t_cnt  [6];

    mem_check_monitor #(.STRICT(1'b0)) dut (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_test(exp_test), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_cnt_we(exp_cnt_we), .exp_cnt(exp_cnt),
        .start(start), .test_sel(test_sel), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .dut_reset(dut_reset), .busy(busy), .done(done), .pass(pass),
        .fail_code(fail_code), .cycles(cycles), .stray(stray), .pass_total(pass_total),
        .bad_addr(bad_addr), .bad_data(bad_data)
    );

    mem_check_monitor #(.STRICT(1'b1)) dut_s (
        .clk(clk), .reset(reset), .exp_we(exp_we), .exp_test(exp_test), .exp_idx(exp_idx),
        .exp_addr(exp_addr), .exp_data(exp_data), .exp_cnt_we(exp_cnt_we), .exp_cnt(exp_cnt),
        .start(start), .test_sel(test_sel), .memwrite(memwrite), .dataadr(dataadr),
        .writedata(writedata), .dut_reset(dut_reset_s), .busy(busy_s), .done(done_s), .pass(pass_s),
        .fail_code(fail_code_s), .cycles(cycles_s), .stray(stray_s), .pass_total(pass_total_s),
        .bad_addr(bad_addr_s), .bad_data(bad_data_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input logic [2:0] t, input logic [1:0] i,
                              input logic [31:0] a, input logic [31:0] d);
        exp_test = t;
        exp_idx  = i;
        exp_addr = a;
        exp_data = d;
        exp_we   = 1'b1;
        tick();
        exp_we   = 1'b0;
    endtask

    task automatic load_cnt(input logic [2:0] t, input logic [2:0] c);
        exp_test   = t;
        exp_cnt    = c;
        exp_cnt_we = 1'b1;
        tick();
        exp_cnt_we = 1'b0;
    endtask

    task automatic start_test(input logic [2:0] sel);
        start    = 1'b1;
        test_sel = sel;
        tick();
        start    = 1'b0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        dataadr   = a;
        writedata = d;
        tick();
        memwrite  = 1'b0;
    endtask

    task automatic idle(input int n);
        memwrite = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_done(input string tag);
        int i = 0;
        while (done !== 1'b1 && i < 400) begin
            tick();
            i++;
        end
        chk(tag, 64'(done), 64'd1);
    endtask

    initial begin
        t_addr[0][0] = 32'd18;         t_data[0][0] = 32'd21; t_cnt[0] = 1;
        t_addr[1][0] = 32'd84;         t_data[1][0] = 32'd7;
        t_addr[1][1] = 32'h10;         t_data[1][1] = 32'd1;  t_cnt[1] = 2;
        t_addr[2][0] = 32'h70f00ff0;   t_data[2][0] = 32'd2;  t_cnt[2] = 1;
        t_addr[3][0] = 32'h100;        t_data[3][0] = 32'hA;  t_cnt[3] = 1;
        t_addr[4][0] = 32'h104;        t_data[4][0] = 32'hB;  t_cnt[4] = 1;
        t_addr[5][0] = 32'h108;        t_data[5][0] = 32'hC;  t_cnt[5] = 1;

        repeat (3) tick();
        chk("rst_dut_reset", 64'(dut_reset), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pass", 64'(pass), 64'd0);
        chk("rst_fail", 64'(fail_code), 64'd0);
        chk("rst_total", 64'(pass_total), 64'd0);
        reset = 1'b1;
        tick();

        for (int s = 0; s < 6; s++) begin
            for (int j = 0; j < t_cnt[s]; j++) load_entry(3'(s), 2'(j), t_addr[s][j], t_data[s][j]);
            load_cnt(3'(s), 3'(t_cnt[s]));
        end

        // Slot 0: single store at RUN cycle 40.
        start_test(3'd0);
        chk("a_busy", 64'(busy), 64'd1);
        chk("a_hold1", 64'(dut_reset), 64'd1);
        tick();
        chk("a_hold2", 64'(dut_reset), 64'd1);
        tick();
        chk("a_run", 64'(dut_reset), 64'd0);
        idle(39);
        chk("a_not_done", 64'(done), 64'd0);
        store(32'd18, 32'd21);
        chk("a_done", 64'(done), 64'd1);
        chk("a_pass", 64'(pass), 64'd1);
        chk("a_fail", 64'(fail_code), 64'd0);
        chk("a_cycles", 64'(cycles), 64'd40);
        chk("a_total", 64'(pass_total), 64'd1);
        tick();
        chk("a_done_pulse", 64'(done), 64'd0);
        chk("a_pass_held", 64'(pass), 64'd1);

        // Slot 1: stores in reverse order.
        start_test(3'd1);
        chk("b_pass_clr", 64'(pass), 64'd0);
        tick();
        tick();
        store(32'h10, 32'd1);
        chk("b_s_done", 64'(done_s), 64'd1);
        chk("b_s_fail", 64'(fail_code_s), 64'd2);
        chk("b_s_bad_addr", 64'(bad_addr_s), 64'h10);
        store(32'd84, 32'd7);
        chk("b_busy", 64'(busy), 64'd1);
        wait_done("b_done");
        chk("b_pass", 64'(pass), 64'd0);
        chk("b_fail", 64'(fail_code), 64'd1);
        chk("b_stray", 64'(stray), 64'd1);
        chk("b_bad_addr", 64'(bad_addr), 64'h10);
        chk("b_bad_data", 64'(bad_data), 64'd1);
        chk("b_cycles", 64'(cycles), 64'd200);
        tick();

        // Slot 2: wrong data to the expected address.
        start_test(3'd2);
        tick();
        tick();
        store(32'h70f00ff0, 32'd3);
        chk("c_s_done", 64'(done_s), 64'd1);
        chk("c_s_fail", 64'(fail_code_s), 64'd2);
        chk("c_s_bad_data", 64'(bad_data_s), 64'd3);
        chk("c_s_bad_addr", 64'(bad_addr_s), 64'h70f00ff0);
        chk("c_s_cycles", 64'(cycles_s), 64'd1);
        chk("c_still_busy", 64'(busy), 64'd1);
        wait_done("c_done");
        chk("c_fail", 64'(fail_code), 64'd1);
        tick();

        // Out-of-range selection.
        start_test(3'd6);
        chk("d_done", 64'(done), 64'd1);
        chk("d_fail", 64'(fail_code), 64'd3);
        chk("d_busy", 64'(busy), 64'd0);
        chk("d_dut_reset", 64'(dut_reset), 64'd1);
        tick();
        chk("d_done_pulse", 64'(done), 64'd0);
        chk("d_dut_reset2", 64'(dut_reset), 64'd1);

        // Zero-count slot: passes on a quiet bus, fails with a stray write.
        load_cnt(3'd3, 3'd0);
        start_test(3'd3);
        tick();
        tick();
        wait_done("e_done");
        chk("e_pass", 64'(pass), 64'd1);
        chk("e_fail", 64'(fail_code), 64'd0);
        chk("e_cycles", 64'(cycles), 64'd200);
        chk("e_total", 64'(pass_total), 64'd2);
        tick();
        start_test(3'd3);
        tick();
        tick();
        store(32'h55, 32'h66);
        wait_done("e2_done");
        chk("e2_pass", 64'(pass), 64'd0);
        chk("e2_fail", 64'(fail_code), 64'd1);
        chk("e2_stray", 64'(stray), 64'd1);
        tick();

        // Final match in the timeout cycle still passes.
        start_test(3'd0);
        tick();
        tick();
        idle(199);
        store(32'd18, 32'd21);
        chk("f_done", 64'(done), 64'd1);
        chk("f_pass", 64'(pass), 64'd1);
        chk("f_cycles", 64'(cycles), 64'd200);
        chk("f_total", 64'(pass_total), 64'd3);
        tick();

        // Reset mid-run.
        start_test(3'd0);
        tick();
        tick();
        idle(9);
        reset = 1'b0;
        tick();
        chk("g_busy", 64'(busy), 64'd0);
        chk("g_dut_reset", 64'(dut_reset), 64'd1);
        chk("g_done", 64'(done), 64'd0);
        chk("g_total", 64'(pass_total), 64'd0);
        chk("g_total_s", 64'(pass_total_s), 64'd0);
        reset = 1'b1;
        tick();
        for (int s = 0; s < 6; s++) load_cnt(3'(s), 3'(t_cnt[s]));

        // Six back-to-back passing tests, then a seventh against the saturated tally.
        for (int s = 0; s < 6; s++) begin
            start_test(3'(s));
            tick();
            tick();
            for (int j = 0; j < t_cnt[s]; j++) store(t_addr[s][j], t_data[s][j]);
            chk($sformatf("h_done_pass_%0d", s), 64'({done, pass}), 64'd3);
            tick();
        end
        chk("h_total", 64'(pass_total), 64'd6);
        chk("h_total_s", 64'(pass_total_s), 64'd6);
        start_test(3'd0);
        tick();
        tick();
        store(32'd18, 32'd21);
        chk("h7_done_pass", 64'({done, pass}), 64'd3);
        chk("h7_total_sat", 64'(pass_total), 64'd6);
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
